// File: rtl/multicycle_controller_if.sv
// Shared memory-port handshake between the controller and the memory.
// The controller (master) issues requests; memory (slave) acknowledges them.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ack
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle processor control FSM.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes, watches memory
// waits for a timeout and counts retired instructions.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [2:0]                     opcode,
    multicycle_controller_if.master        mem,
    output logic                           ir_load,
    output logic                           pc_inc,
    output logic                           reg_we,
    output logic                           wb_sel,
    output logic [1:0]                     alu_op,
    output logic                           busy,
    output logic                           halted,
    output logic                           fault,
    output logic [2:0]                     state,
    output logic [15:0]                    instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_ADD   = 3'b011,
        OP_SUB   = 3'b100,
        OP_AND   = 3'b101,
        OP_OR    = 3'b110,
        OP_HALT  = 3'b111
    } op_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t      state_q;
    op_t         op_q;
    logic [7:0]  wait_cnt;
    logic        fault_q;
    logic [15:0] instret_q;

    // Sequencing, opcode latch, memory-wait watchdog and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NOP;
            wait_cnt  <= '0;
            fault_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_FETCH;
                        wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (mem.mem_ack) begin
                        state_q <= S_DECODE;
                    end else if (wait_cnt == TIMEOUT) begin
                        fault_q <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    op_q <= op_t'(opcode);
                    case (op_t'(opcode))
                        OP_NOP: begin
                            state_q   <= S_FETCH;
                            wait_cnt  <= '0;
                            instret_q <= instret_q + 16'd1;
                        end
                        OP_LOAD, OP_STORE: begin
                            state_q  <= S_MEM;
                            wait_cnt <= '0;
                        end
                        OP_HALT: state_q <= S_HALT;
                        default: state_q <= S_EXEC;
                    endcase
                end
                S_EXEC: state_q <= S_WB;
                S_MEM: begin
                    if (mem.mem_ack) begin
                        if (op_q == OP_STORE) begin
                            state_q   <= S_FETCH;
                            wait_cnt  <= '0;
                            instret_q <= instret_q + 16'd1;
                        end else begin
                            state_q <= S_WB;
                        end
                    end else if (wait_cnt == TIMEOUT) begin
                        fault_q <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    state_q   <= S_FETCH;
                    wait_cnt  <= '0;
                    instret_q <= instret_q + 16'd1;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobe decode from state/op_q; ir_load and pc_inc also need mem_ack.
    always_comb begin
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        ir_load          = 1'b0;
        pc_inc           = 1'b0;
        reg_we           = 1'b0;
        wb_sel           = 1'b0;
        alu_op           = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                ir_load     = mem.mem_ack;
                pc_inc      = mem.mem_ack;
            end
            S_MEM: begin
                mem.mem_req      = 1'b1;
                mem.mem_addr_sel = 1'b1;
                mem.mem_we       = (op_q == OP_STORE);
            end
            S_EXEC, S_WB: begin
                case (op_q)
                    OP_SUB:  alu_op = 2'b01;
                    OP_AND:  alu_op = 2'b10;
                    OP_OR:   alu_op = 2'b11;
                    default: alu_op = 2'b00;
                endcase
                if (state_q == S_WB) begin
                    reg_we = 1'b1;
                    wb_sel = (op_q == OP_LOAD);
                end
            end
            default: ;
        endcase
    end

    // Status outputs straight from the registers.
    always_comb begin
        busy    = (state_q != S_IDLE) && (state_q != S_HALT);
        halted  = (state_q == S_HALT);
        fault   = fault_q;
        state   = state_q;
        instret = instret_q;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into its
// expected per-cycle trace (inputs to drive plus outputs required), then the
// trace is replayed cycle by cycle against the DUT.
module tb_multicycle_controller;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  opcode = 3'b000;
    logic        ir_load, pc_inc, reg_we, wb_sel, busy, halted, fault;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic [15:0] instret;

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .opcode  (opcode),
        .mem     (bus),
        .ir_load (ir_load),
        .pc_inc  (pc_inc),
        .reg_we  (reg_we),
        .wb_sel  (wb_sel),
        .alu_op  (alu_op),
        .busy    (busy),
        .halted  (halted),
        .fault   (fault),
        .state   (state),
        .instret (instret)
    );

    always #5 clk = ~clk;

    // Strobe groups {req, we, addr_sel, ir_load, pc_inc, reg_we, wb_sel}.
    localparam logic [6:0] Z  = 7'b0000000;
    localparam logic [6:0] FW = 7'b1000000;
    localparam logic [6:0] FA = 7'b1001100;
    localparam logic [6:0] MR = 7'b1010000;
    localparam logic [6:0] MW = 7'b1110000;
    localparam logic [6:0] WL = 7'b0000011;
    localparam logic [6:0] WA = 7'b0000010;

    typedef struct {
        bit          chk;
        logic        r;
        logic        s;
        logic        a;
        logic [2:0]  o;
        logic [30:0] expv;
    } cyc_t;

    cyc_t        q[$];
    logic [15:0] m_instret = '0;
    logic        m_fault = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          pc_cnt = 0;

    function automatic void push(bit c, logic r, logic s, logic a, logic [2:0] o,
                                 logic [2:0] st, logic [6:0] strb, logic [1:0] alu);
        cyc_t e;
        logic bz, hl;
        bz = (st != 3'd0) && (st != 3'd6);
        hl = (st == 3'd6);
        e.chk = c; e.r = r; e.s = s; e.a = a; e.o = o;
        e.expv = {st, strb, alu, bz, hl, m_fault, m_instret};
        q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_instret = '0;
        m_fault   = 1'b0;
    endfunction

    function automatic void f_idle(logic s);
        push(1, 0, s, 0, 3'b111, 3'd0, Z, 2'b00);
    endfunction

    function automatic void f_fetch(logic [2:0] op, int n, logic s);
        for (int i = 0; i < n; i++) push(1, 0, s, 0, ~op, 3'd1, FW, 2'b00);
        push(1, 0, s, 1, ~op, 3'd1, FA, 2'b00);
    endfunction

    function automatic void f_halt(int n, logic s);
        for (int i = 0; i < n; i++) push(1, 0, s, 0, 3'b000, 3'd6, Z, 2'b00);
    endfunction

    function automatic void f_instr(logic [2:0] op, int fw, int mw);
        logic [6:0] ms;
        logic [1:0] code;
        f_fetch(op, fw, 0);
        push(1, 0, 0, 0, op, 3'd2, Z, 2'b00);
        if (op == 3'd0) begin
            m_instret++;
        end else if (op == 3'd1 || op == 3'd2) begin
            ms = (op == 3'd2) ? MW : MR;
            for (int i = 0; i < mw; i++) push(1, 0, 0, 0, ~op, 3'd4, ms, 2'b00);
            push(1, 0, 0, 1, ~op, 3'd4, ms, 2'b00);
            if (op == 3'd2) begin
                m_instret++;
            end else begin
                push(1, 0, 0, 0, ~op, 3'd5, WL, 2'b00);
                m_instret++;
            end
        end else if (op != 3'd7) begin
            code = 2'(op - 3'd3);
            push(1, 0, 0, 0, ~op, 3'd3, Z, code);
            push(1, 0, 0, 0, ~op, 3'd5, WA, code);
            m_instret++;
        end
    endfunction

    task automatic run_q(input string seg);
        cyc_t e;
        logic [30:0] act;
        int idx;
        idx = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.r; start = e.s; bus.mem_ack = e.a; opcode = e.o;
            #1;
            if (pc_inc) pc_cnt++;
            if (e.chk) begin
                act = {state, bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_load, pc_inc,
                       reg_we, wb_sel, alu_op, busy, halted, fault, instret};
                checks++;
                if (act !== e.expv) begin
                    failures++;
                    $display("FAIL %s cycle %0d: got %h expected %h", seg, idx, act, e.expv);
                end
            end
            idx++;
        end
    endtask

    task automatic check_lit(input string n, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, expv);
        end
    endtask

    initial begin
        bus.mem_ack = 1'b0;

        // Reset, then a zero-wait stream ADD, LOAD, STORE, NOP, HALT.
        push(0, 1, 0, 0, 3'b000, 3'd0, Z, 2'b00);
        model_reset();
        f_idle(0);
        run_q("reset");
        check_lit("reset_state", 16'(state), 16'd0);
        check_lit("reset_instret", instret, 16'd0);
        f_idle(1);
        f_instr(3'd3, 0, 0);
        f_instr(3'd1, 0, 0);
        f_instr(3'd2, 0, 0);
        f_instr(3'd0, 0, 0);
        f_instr(3'd7, 0, 0);
        f_halt(3, 1);
        pc_cnt = 0;
        run_q("stream");
        check_lit("stream_instret", instret, 16'd4);
        check_lit("stream_halted", 16'(halted), 16'd1);
        check_lit("stream_state", 16'(state), 16'd6);
        check_lit("stream_pc_inc", 16'(pc_cnt), 16'd5);

        // Reset out of HALT; waited LOAD, ALU ops, ack on the timeout limit.
        push(1, 1, 0, 0, 3'b000, 3'd6, Z, 2'b00);
        model_reset();
        f_idle(1);
        f_fetch(3'd1, 1, 1);
        push(1, 0, 0, 0, 3'd1, 3'd2, Z, 2'b00);
        for (int i = 0; i < 3; i++) push(1, 0, 0, 0, 3'd6, 3'd4, MR, 2'b00);
        push(1, 0, 0, 1, 3'd6, 3'd4, MR, 2'b00);
        push(1, 0, 0, 0, 3'd6, 3'd5, WL, 2'b00);
        m_instret++;
        f_instr(3'd4, 0, 0);
        f_instr(3'd5, 0, 0);
        f_instr(3'd6, 0, 0);
        f_instr(3'd3, TO, 0);
        run_q("waits");
        check_lit("limit_ack_fault", 16'(fault), 16'd0);

        // Reset during MEM of a STORE, then restart.
        f_fetch(3'd2, 0, 0);
        push(1, 0, 0, 0, 3'd2, 3'd2, Z, 2'b00);
        push(1, 0, 0, 0, 3'd5, 3'd4, MW, 2'b00);
        push(1, 1, 0, 0, 3'd5, 3'd4, MW, 2'b00);
        model_reset();
        f_idle(0);
        run_q("mem_reset");
        check_lit("mem_reset_req", 16'(bus.mem_req), 16'd0);
        check_lit("mem_reset_instret", instret, 16'd0);
        f_idle(1);
        f_instr(3'd0, 0, 0);
        run_q("restart");
        check_lit("restart_instret", instret, 16'd0);

        // FETCH timeout: no ack for MEM_TIMEOUT+1 cycles.
        for (int i = 0; i <= TO; i++) push(1, 0, 0, 0, 3'b000, 3'd1, FW, 2'b00);
        m_fault = 1'b1;
        f_halt(3, 1);
        run_q("fetch_timeout");
        check_lit("fetch_timeout_fault", 16'(fault), 16'd1);
        check_lit("fetch_timeout_state", 16'(state), 16'd6);

        // MEM timeout on a LOAD.
        push(1, 1, 0, 0, 3'b000, 3'd6, Z, 2'b00);
        model_reset();
        f_idle(1);
        f_fetch(3'd1, 0, 0);
        push(1, 0, 0, 0, 3'd1, 3'd2, Z, 2'b00);
        for (int i = 0; i <= TO; i++) push(1, 0, 0, 0, 3'd0, 3'd4, MR, 2'b00);
        m_fault = 1'b1;
        f_halt(2, 0);
        run_q("mem_timeout");
        check_lit("mem_timeout_fault", 16'(fault), 16'd1);

        // instret wrap after 65536 NOPs.
        push(1, 1, 0, 0, 3'b000, 3'd6, Z, 2'b00);
        model_reset();
        f_idle(1);
        for (int i = 0; i < 65535; i++) f_instr(3'd0, 0, 0);
        push(1, 0, 0, 0, 3'b111, 3'd1, FW, 2'b00);
        run_q("nop_fill");
        check_lit("instret_max", instret, 16'hFFFF);
        f_instr(3'd0, 0, 0);
        push(1, 0, 0, 0, 3'b111, 3'd1, FW, 2'b00);
        run_q("nop_wrap");
        check_lit("instret_wrap", instret, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
